// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: word-organised memory that answers the LC-3b
// mem_read/mem_write/mem_resp handshake. It accepts one level-held request at
// a time and returns a one-cycle mem_resp LATENCY cycles after the request
// first appears. Byte-lane writes are selected by mem_byte_enable.
//
// Optional feature: define MEM_JITTER_EN to add 0..3 pseudo-random extra
// cycles of latency per request, drawn from an 8-bit LFSR.
//
// Ports:
//   clk              clock, all logic on posedge
//   rst_n            synchronous active-low reset; aborts any request in flight
//   mem_address      byte address; bit 0 and bits above ADDR_BITS are ignored
//   mem_read         read request, held until mem_resp
//   mem_write        write request, held until mem_resp (wins over mem_read)
//   mem_byte_enable  write lane mask: [1] -> [15:8], [0] -> [7:0]
//   mem_wdata        write data
//   mem_rdata        registered read data, valid with mem_resp, held until next read
//   mem_resp         one-cycle completion pulse
module lc3b_mem_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [ADDR_BITS-1:0]   lat_addr;
    logic                   lat_we;
    logic [1:0]             lat_be;
    logic [15:0]            lat_wdata;
    logic [15:0]            mem [DEPTH];

    logic                   req_c;
    logic                   accept_c;
    logic                   go_resp_c;
    logic [CNT_W-1:0]       extra_c;
    logic [CNT_W-1:0]       load_c;
    logic [ADDR_BITS-1:0]   op_addr_c;
    logic                   op_we_c;
    logic [1:0]             op_be_c;
    logic [15:0]            op_wdata_c;
    logic                   unused_addr_bits;

    // Address bits outside the word index are deliberately ignored (aliasing).
    assign unused_addr_bits = ^{mem_address[0], mem_address[15:ADDR_BITS+1]};

`ifdef MEM_JITTER_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, free-running every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign extra_c = CNT_W'(lfsr[1:0]);
`else
    assign extra_c = '0;
`endif

    // Acceptance decode and selection of the operation about to complete.
    // With a zero load value the request completes on its acceptance edge,
    // so the live inputs are used instead of the (not yet written) latches.
    always_comb begin
        req_c      = mem_read | mem_write;
        accept_c   = 1'b0;
        go_resp_c  = 1'b0;
        load_c     = CNT_W'(LATENCY - 1) + extra_c;
        op_addr_c  = lat_addr;
        op_we_c    = lat_we;
        op_be_c    = lat_be;
        op_wdata_c = lat_wdata;
        if (state == IDLE && req_c) begin
            accept_c   = 1'b1;
            go_resp_c  = (load_c == '0);
            op_addr_c  = mem_address[ADDR_BITS:1];
            op_we_c    = mem_write;
            op_be_c    = mem_byte_enable;
            op_wdata_c = mem_wdata;
        end else if (state == BUSY && count == CNT_W'(1)) begin
            go_resp_c  = 1'b1;
        end
    end

    // Control FSM, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            mem_resp  <= 1'b0;
            mem_rdata <= 16'h0000;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_be    <= 2'b00;
            lat_wdata <= 16'h0000;
        end else begin
            mem_resp <= go_resp_c;
            if (go_resp_c && !op_we_c) begin
                mem_rdata <= mem[op_addr_c];
            end
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        lat_addr  <= mem_address[ADDR_BITS:1];
                        lat_we    <= mem_write;
                        lat_be    <= mem_byte_enable;
                        lat_wdata <= mem_wdata;
                        count     <= load_c;
                        state     <= go_resp_c ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    count <= count - CNT_W'(1);
                    if (go_resp_c) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; a reset edge suppresses the pending commit.
    always_ff @(posedge clk) begin
        if (rst_n && go_resp_c && op_we_c) begin
            if (op_be_c[0]) begin
                mem[op_addr_c][7:0] <= op_wdata_c[7:0];
            end
            if (op_be_c[1]) begin
                mem[op_addr_c][15:8] <= op_wdata_c[15:8];
            end
        end
    end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: transaction-level reference model checked
// against the DUT every cycle, plus directed scenarios with literal values.
module tb_lc3b_mem_responder;

    localparam int unsigned AB  = 10;
    localparam int unsigned LAT = 3;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    int checks = 0;
    int errors = 0;

    lc3b_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (edge-numbered transactions) ----------
    logic [15:0] mm [1 << AB];
    int          ec        = 0;
    int          idle_from = 0;
    int          done_edge = 0;
    bit          pending   = 0;
    bit          m_w;
    int          m_a;
    logic [1:0]  m_be;
    logic [15:0] m_d;
    logic [7:0]  m_lfsr    = 8'hA5;
    logic        exp_resp  = 1'b0;
    logic [15:0] exp_rdata = 16'h0000;
    bit          chk_en    = 0;

    task automatic model_complete();
        if (m_w) begin
            if (m_be[0]) mm[m_a][7:0]  = m_d[7:0];
            if (m_be[1]) mm[m_a][15:8] = m_d[15:8];
        end else begin
            exp_rdata = mm[m_a];
        end
        exp_resp  = 1'b1;
        pending   = 0;
        idle_from = ec + 2;
    endtask

    always @(posedge clk) begin
        int extra;
        ec++;
        exp_resp = 1'b0;
        if (!rst_n) begin
            pending   = 0;
            exp_rdata = 16'h0000;
            idle_from = ec + 1;
            m_lfsr    = 8'hA5;
        end else begin
            if (pending && ec == done_edge) begin
                model_complete();
            end else if (!pending && ec >= idle_from && (mem_read || mem_write)) begin
`ifdef MEM_JITTER_EN
                extra = int'(m_lfsr[1:0]);
`else
                extra = 0;
`endif
                pending   = 1;
                m_w       = mem_write;
                m_a       = int'(mem_address[AB:1]);
                m_be      = mem_byte_enable;
                m_d       = mem_wdata;
                done_edge = ec + int'(LAT) - 1 + extra;
                if (done_edge == ec) model_complete();
            end
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (mem_resp !== exp_resp) begin
                errors++;
                $display("FAIL resp cyc=%0d got=%b exp=%b", ec, mem_resp, exp_resp);
            end
            checks++;
            if (mem_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rdata cyc=%0d got=%h exp=%h", ec, mem_rdata, exp_rdata);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_lat(input string name, input int lat);
        bit ok;
`ifdef MEM_JITTER_EN
        ok = (lat >= int'(LAT)) && (lat <= int'(LAT) + 3);
`else
        ok = (lat == int'(LAT));
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s latency got=%0d exp=%0d(+jitter)", name, lat, LAT);
        end
    endtask

    task automatic wait_resp(input string name, output int lat);
        lat = -1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (mem_resp === 1'b1) begin
                lat = k;
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got=no_resp exp=resp", name);
        end
    endtask

    task automatic do_req(input string name, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [1:0] be,
                          input logic [15:0] d, output int lat);
        @(negedge clk);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = a;
        mem_byte_enable = be;
        mem_wdata       = d;
        wait_resp(name, lat);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int         lat;
        int         nresp;
        logic [10:0] seen;
        int         lats1 [50];
        int         lats2 [50];
        logic [15:0] jaddr [4];
        logic [15:0] jdata [4];
        int         pick  [50];

        rst_n           = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 16'h0000;
        mem_byte_enable = 2'b00;
        mem_wdata       = 16'h0000;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check16("reset_resp", 16'(mem_resp), 16'h0000);
        check16("reset_rdata", mem_rdata, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. write then read back
        do_req("t1_wr", 1'b0, 1'b1, 16'h0010, 2'b11, 16'h1234, lat);
        check_lat("t1_wr", lat);
        do_req("t1_rd", 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat);
        check_lat("t1_rd", lat);
        check16("t1_rdata", mem_rdata, 16'h1234);

        // 2. byte lanes
        do_req("t2_pre", 1'b0, 1'b1, 16'h0020, 2'b11, 16'hFFFF, lat);
        do_req("t2_hi", 1'b0, 1'b1, 16'h0020, 2'b10, 16'hAB00, lat);
        do_req("t2_rd1", 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, lat);
        check16("t2_hi_lane", mem_rdata, 16'hABFF);
        do_req("t2_lo", 1'b0, 1'b1, 16'h0020, 2'b01, 16'h00CD, lat);
        do_req("t2_rd2", 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, lat);
        check16("t2_lo_lane", mem_rdata, 16'hABCD);
        do_req("t2_none", 1'b0, 1'b1, 16'h0020, 2'b00, 16'h1234, lat);
        check_lat("t2_none", lat);
        check16("t2_wr_keeps_rdata", mem_rdata, 16'hABCD);
        do_req("t2_rd3", 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, lat);
        check16("t2_be00", mem_rdata, 16'hABCD);

        // 3. read held for 10 cycles
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 16'h0010;
        seen        = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            seen[k] = mem_resp;
        end
        mem_read = 1'b0;
`ifndef MEM_JITTER_EN
        check16("t3_pulses", 16'(seen), 16'h0088);
`endif
        repeat (8) @(negedge clk);

        // 4. reset mid-write
        do_req("t4_pre", 1'b0, 1'b1, 16'h0030, 2'b11, 16'h1111, lat);
        @(negedge clk);
        mem_write       = 1'b1;
        mem_address     = 16'h0030;
        mem_byte_enable = 2'b11;
        mem_wdata       = 16'h5555;
        nresp = 0;
        @(negedge clk);
        nresp += int'(mem_resp);
        @(negedge clk);
        nresp += int'(mem_resp);
        rst_n     = 1'b0;
        mem_write = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            nresp += int'(mem_resp);
            if (k == 1) rst_n = 1'b1;
        end
        check16("t4_no_resp", 16'(nresp), 16'h0000);
        check16("t4_rdata_cleared", mem_rdata, 16'h0000);
        do_req("t4_rd", 1'b1, 1'b0, 16'h0030, 2'b00, 16'h0000, lat);
        check16("t4_old_kept", mem_rdata, 16'h1111);

        // 5. latching and aliasing
        @(negedge clk);
        mem_write       = 1'b1;
        mem_address     = 16'h0041;
        mem_byte_enable = 2'b11;
        mem_wdata       = 16'h0F0F;
        @(negedge clk);
        mem_address = 16'h0050;
        mem_wdata   = 16'hDEAD;
        mem_byte_enable = 2'b01;
        wait_resp("t5_wr", lat);
        check_lat("t5_wr", lat + 1);
        do_req("t5_rd", 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, lat);
        check16("t5_latched", mem_rdata, 16'h0F0F);
        do_req("t5_alias_wr", 1'b0, 1'b1, 16'h0800, 2'b11, 16'hBEEF, lat);
        do_req("t5_alias_rd", 1'b1, 1'b0, 16'h0000, 2'b00, 16'h0000, lat);
        check16("t5_alias", mem_rdata, 16'hBEEF);

        // read and write together behave as a write
        do_req("rw_both", 1'b1, 1'b1, 16'h0060, 2'b11, 16'h7777, lat);
        check16("rw_rdata_kept", mem_rdata, 16'hBEEF);
        do_req("rw_rd", 1'b1, 1'b0, 16'h0060, 2'b00, 16'h0000, lat);
        check16("rw_written", mem_rdata, 16'h7777);

`ifdef MEM_JITTER_EN
        // 6. random reads with jitter, repeated after reset
        jaddr[0] = 16'h0010; jdata[0] = 16'h1234;
        jaddr[1] = 16'h0020; jdata[1] = 16'hABCD;
        jaddr[2] = 16'h0030; jdata[2] = 16'h1111;
        jaddr[3] = 16'h0040; jdata[3] = 16'h0F0F;
        for (int i = 0; i < 50; i++) pick[i] = int'($urandom_range(3, 0));
        for (int p = 0; p < 2; p++) begin
            do_reset();
            for (int i = 0; i < 50; i++) begin
                do_req("t6_rd", 1'b1, 1'b0, jaddr[pick[i]], 2'b00, 16'h0000, lat);
                check_lat("t6_lat", lat);
                check16("t6_data", mem_rdata, jdata[pick[i]]);
                if (p == 0) lats1[i] = lat; else lats2[i] = lat;
            end
        end
        for (int i = 0; i < 50; i++) check16("t6_repeat", 16'(lats2[i]), 16'(lats1[i]));
`else
        jaddr[0] = 16'h0; jdata[0] = 16'h0; pick[0] = 0; lats1[0] = 0; lats2[0] = 0;
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
